core_exec_sched: RTL
====================

// Module: core_exec_sched
// PURPOSE
//  Sequences the core's execution engines (single-cycle ALU, fixed-latency pipelined MUL, variable-latency iterative DIV).
//  Accepts one issued op at a time with valid/ready and launches the selected engine.
//  Waits out that engine's latency, then registers its result and presents it to writeback with valid/ready.
//  Sits between decode/issue and writeback; flush aborts in-flight work on redirect/trap.
// PARAMETERS
//  MUL_LATENCY  2   cycles from mul_start to mul_result valid; legal range 1..15
// PORTS
//  clk         in   1   core clock
//  rst         in   1   synchronous, active-high reset
//  flush       in   1   abort in-flight op and any held result
//  in_valid    in   1   issue has an op
//  in_ready    out  1   scheduler can accept an op this cycle
//  in_engine   in   exec_engine_e  engine select from decoder (EXEC_ALU/EXEC_MUL/EXEC_DIV)
//  alu_result  in   32  ALU output, valid in the accept cycle
//  mul_result  in   32  MUL output, valid MUL_LATENCY cycles after mul_start
//  div_result  in   32  DIV output, valid while div_done=1
//  mul_start   out  1   one-cycle launch pulse to multiplier
//  div_start   out  1   one-cycle launch pulse to divider
//  div_done    in   1   divider completion, single-cycle pulse
//  div_kill    out  1   one-cycle abort to divider
//  out_valid   out  1   out_result holds a completed result
//  out_ready   in   1   writeback consumes the result
//  out_result  out  32  registered result
//  busy        out  1   state != S_IDLE or out_valid
// BEHAVIOUR
//  Reset: state=S_IDLE, out_valid=0, out_result=0, mul counter=0, all pulses 0, perf counters 0.
//  Transfer rules:
//   - accept = in_valid & in_ready
//   - in_ready = (state==S_IDLE) & (!out_valid | out_ready) & !flush
//   - output handshake completes when out_valid & out_ready; out_valid and out_result stay stable until then.
//  States (exec_state_e): S_IDLE, S_MUL_WAIT, S_DIV_WAIT.
//  ALU, or any undefined in_engine encoding: on accept, out_result<=alu_result and out_valid<=1; state stays S_IDLE.
//   - Latency 1 (accept at T, out_valid at T+1).
//   - Back-to-back ALU ops at one per cycle while out_ready=1.
//  MUL: mul_start=accept&(in_engine==EXEC_MUL), combinational, same cycle.
//   - Counter loads MUL_LATENCY-1; go to S_MUL_WAIT.
//   - Counter decrements each cycle; at 0 capture mul_result, set out_valid, go to S_IDLE.
//   - out_valid at T+MUL_LATENCY+1.
//  DIV: div_start=accept&(in_engine==EXEC_DIV); go to S_DIV_WAIT.
//   - On div_done: capture div_result, set out_valid, go to S_IDLE.
//   - div_done outside S_DIV_WAIT is ignored.
//  Capture never overwrites an unconsumed result; the in_ready gate guarantees out_valid=0 or consumed at capture.
//  Flush (highest priority over every other event in its cycle):
//   - out_valid<=0, state<=S_IDLE, counter<=0; no accept that cycle.
//   - div_kill=1 if state==S_DIV_WAIT; a same-cycle div_done is discarded.
//   - An in-flight MUL result is dropped; the multiplier needs no kill (pipelined).
//  rst mid-operation: same effect as reset values; div_kill is NOT driven (divider shares rst).
// CONFIGURATION
//  CORE_EXEC_PERF_EN defined: adds output ports, each 32-bit and wrap-around:
//   - perf_mul_cnt: +1 per MUL accept
//   - perf_div_cnt: +1 per DIV accept
//   - perf_stall_cnt: +1 per cycle with in_valid & !in_ready
//   - All counters cleared by rst only, not by flush.
//  CORE_EXEC_PERF_EN undefined: those ports and counters do not exist; all other behaviour identical.
// STRUCTURE
//  core_pkg: reuse exec_engine_e; add exec_state_e {S_IDLE,S_MUL_WAIT,S_DIV_WAIT} and MUL_CNT_W=4.
//  Sub-module core_exec_perf: holds the three counters; instantiated only under CORE_EXEC_PERF_EN.
//  Result select: an internal case on the captured engine, with no separate mux block.
// TESTING
//  1 ALU stream: 3 consecutive ALU accepts (alu_result 0x1,0x2,0x3), out_ready=1 -> out_result 0x1,0x2,0x3 on 3 consecutive cycles from T+1.
//  2 MUL: MUL_LATENCY=2, accept at T -> mul_start=1 at T only, in_ready=0 during T+1..T+2, out_valid at T+3 with mul_result sampled at T+2.
//  3 DIV: accept at T, div_done at T+33 with 0xFFFFFFFF -> out_valid at T+34 with 0xFFFFFFFF; no accept in between.
//  4 Backpressure: out_ready=0 for 5 cycles after ALU result 0xA5 -> out_result stays 0xA5, in_ready=0, perf_stall_cnt=5 (PERF_EN).
//  5 Flush in S_DIV_WAIT at the same cycle as div_done -> div_kill=1 for 1 cycle, out_valid stays 0, next cycle in_ready=1.
//  6 rst asserted in S_MUL_WAIT -> next cycle state S_IDLE, out_valid=0, no stale capture; MUL accept afterwards completes normally.

Source files
------------

// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared core types for the execution scheduler
package core_pkg;

  typedef enum logic [1:0] {
    EXEC_ALU = 2'd0,
    EXEC_MUL = 2'd1,
    EXEC_DIV = 2'd2
  } exec_engine_e;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MUL_WAIT = 2'd1,
    S_DIV_WAIT = 2'd2
  } exec_state_e;

  localparam int MUL_CNT_W = 4;

endpackage

// File: rtl/core_exec_perf.sv
// rtl/core_exec_perf.sv - wrap-around event counters for the execution scheduler
module core_exec_perf (
  input  logic        clk,
  input  logic        rst,
  input  logic        mul_acc,
  input  logic        div_acc,
  input  logic        stall,
  output logic [31:0] perf_mul_cnt,
  output logic [31:0] perf_div_cnt,
  output logic [31:0] perf_stall_cnt
);

  logic [31:0] mul_cnt_q, mul_cnt_d;
  logic [31:0] div_cnt_q, div_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    mul_cnt_d   = mul_cnt_q + {31'd0, mul_acc};
    div_cnt_d   = div_cnt_q + {31'd0, div_acc};
    stall_cnt_d = stall_cnt_q + {31'd0, stall};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mul_cnt_q   <= '0;
      div_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      mul_cnt_q   <= mul_cnt_d;
      div_cnt_q   <= div_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign perf_mul_cnt   = mul_cnt_q;
  assign perf_div_cnt   = div_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;

endmodule

// File: rtl/core_exec_sched.sv
// rtl/core_exec_sched.sv - sequences ALU/MUL/DIV engines from issue to writeback
// Define CORE_EXEC_PERF_EN to add the perf_* counter ports.
module core_exec_sched
  import core_pkg::*;
#(
  parameter int MUL_LATENCY = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  exec_engine_e in_engine,
  input  logic [31:0]  alu_result,
  input  logic [31:0]  mul_result,
  input  logic [31:0]  div_result,
  output logic         mul_start,
  output logic         div_start,
  input  logic         div_done,
  output logic         div_kill,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  out_result,
  output logic         busy
`ifdef CORE_EXEC_PERF_EN
  ,
  output logic [31:0]  perf_mul_cnt,
  output logic [31:0]  perf_div_cnt,
  output logic [31:0]  perf_stall_cnt
`endif
);

  exec_state_e          state_q, state_d;
  logic [MUL_CNT_W-1:0] cnt_q, cnt_d;
  logic                 out_valid_q, out_valid_d;
  logic [31:0]          out_result_q, out_result_d;
  logic                 accept;

  // Gating on rst keeps every launch pulse low while the engines are held in reset.
  assign in_ready  = (state_q == S_IDLE) & (~out_valid_q | out_ready) & ~flush & ~rst;
  assign accept    = in_valid & in_ready;
  assign mul_start = accept & (in_engine == EXEC_MUL);
  assign div_start = accept & (in_engine == EXEC_DIV);
  assign div_kill  = flush & ~rst & (state_q == S_DIV_WAIT);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    if (out_valid_q & out_ready) out_valid_d = 1'b0;
    // The state doubles as the captured engine, so it selects the result source.
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (in_engine)
            EXEC_MUL: begin
              state_d = S_MUL_WAIT;
              cnt_d   = MUL_CNT_W'(MUL_LATENCY - 1);
            end
            EXEC_DIV: state_d = S_DIV_WAIT;
            default: begin
              out_valid_d  = 1'b1;
              out_result_d = alu_result;
            end
          endcase
        end
      end
      S_MUL_WAIT: begin
        if (cnt_q == '0) begin
          out_valid_d  = 1'b1;
          out_result_d = mul_result;
          state_d      = S_IDLE;
        end else begin
          cnt_d = cnt_q - MUL_CNT_W'(1);
        end
      end
      S_DIV_WAIT: begin
        if (div_done) begin
          out_valid_d  = 1'b1;
          out_result_d = div_result;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      state_d     = S_IDLE;
      cnt_d       = '0;
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign busy       = (state_q != S_IDLE) | out_valid_q;

`ifdef CORE_EXEC_PERF_EN
  core_exec_perf u_perf (
    .clk            (clk),
    .rst            (rst),
    .mul_acc        (mul_start),
    .div_acc        (div_start),
    .stall          (in_valid & ~in_ready),
    .perf_mul_cnt   (perf_mul_cnt),
    .perf_div_cnt   (perf_div_cnt),
    .perf_stall_cnt (perf_stall_cnt)
  );
`endif

endmodule
